// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants for the systolic skew feeder.
// Default array geometry and FSM state encodings.
package systolic_skew_feeder_pkg;

    localparam int SSF_DATA_W = 8;
    localparam int SSF_N      = 4;
    localparam int SSF_K_MAX  = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/systolic_operand_bank.sv
// Operand buffer: N lanes x K_MAX entries, slice-wide write port,
// one independent read per lane with write-through forwarding.
module systolic_operand_bank #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int K_MAX  = 8,
    parameter int IDX_W  = $clog2(K_MAX)
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [N*DATA_W-1:0]      wr_data_i,
    input  logic [N-1:0][IDX_W-1:0]  rd_idx_i,
    output logic [N-1:0][DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [N][K_MAX];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int x = 0; x < N; x++) begin
                mem_q[x][wr_idx_i] <= wr_data_i[x*DATA_W +: DATA_W];
            end
        end
    end

    // Forwarding lets the first stream cycle use the slice written on that edge.
    always_comb begin
        rd_data_o = '0;
        for (int x = 0; x < N; x++) begin
            if (we_i && (wr_idx_i == rd_idx_i[x])) begin
                rd_data_o[x] = wr_data_i[x*DATA_W +: DATA_W];
            end else begin
                rd_data_o[x] = mem_q[x][rd_idx_i[x]];
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge driver for an N x N output-stationary systolic MAC array:
// buffers one A/B tile, then streams it with diagonal skew.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int DATA_W = SSF_DATA_W,
    parameter int N      = SSF_N,
    parameter int K_MAX  = SSF_K_MAX
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [N*DATA_W-1:0]        ld_a,
    input  logic [N*DATA_W-1:0]        ld_b,
    output logic [N*DATA_W-1:0]        a_out,
    output logic [N*DATA_W-1:0]        b_out,
    output logic [2*N-2:0]             clear_diag,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int K_W   = $clog2(K_MAX + 1);
    localparam int IDX_W = $clog2(K_MAX);
    localparam int S_W   = $clog2(K_MAX + 2*N - 1);

    logic [1:0]               state_q, state_d;
    logic [K_W-1:0]           klen_q, klen_d;
    logic [IDX_W-1:0]         k_q, k_d;
    logic [S_W-1:0]           s_q, s_d;
    logic [S_W-1:0]           s_last;
    logic                     err_d;
    logic                     klen_ok;
    logic                     wr_en;
    logic                     stream_d;
    logic [N-1:0][IDX_W-1:0]  rd_idx;
    logic [N-1:0]             lane_on;
    logic [N-1:0][DATA_W-1:0] a_rd, b_rd;
    logic [N*DATA_W-1:0]      a_d, b_d, a_q, b_q;
    logic [2*N-2:0]           clr_d, clr_q;
    logic                     ready_q, busy_q, done_q, err_q;

    assign klen_ok  = (k_len != '0) && (k_len <= K_W'(K_MAX));
    assign wr_en    = (state_q == ST_LOAD) && ld_valid;
    assign s_last   = S_W'(klen_q) + S_W'(2*N - 3);
    assign stream_d = (state_d == ST_STREAM);

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        k_d     = k_q;
        s_d     = s_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (klen_ok) begin
                        state_d = ST_LOAD;
                        klen_d  = k_len;
                        k_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    if (K_W'(k_q) == klen_q - K_W'(1)) begin
                        state_d = ST_STREAM;
                        s_d     = '0;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (s_q == s_last) begin
                    state_d = ST_DONE;
                end else begin
                    s_d = s_q + S_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane x reads entry s-x; lanes outside the skew window emit zero.
    always_comb begin
        rd_idx  = '0;
        lane_on = '0;
        clr_d   = '0;
        for (int x = 0; x < N; x++) begin
            rd_idx[x]  = IDX_W'(s_d - S_W'(x));
            lane_on[x] = stream_d && (s_d >= S_W'(x))
                      && ((s_d - S_W'(x)) < S_W'(klen_q));
        end
        for (int d = 0; d < 2*N - 1; d++) begin
            clr_d[d] = stream_d && (s_d == S_W'(d));
        end
    end

    always_comb begin
        a_d = '0;
        b_d = '0;
        for (int x = 0; x < N; x++) begin
            a_d[x*DATA_W +: DATA_W] = lane_on[x] ? a_rd[x] : '0;
            b_d[x*DATA_W +: DATA_W] = lane_on[x] ? b_rd[x] : '0;
        end
    end

    systolic_operand_bank #(
        .DATA_W (DATA_W),
        .N      (N),
        .K_MAX  (K_MAX),
        .IDX_W  (IDX_W)
    ) u_bank_a (
        .clk       (clk),
        .we_i      (wr_en),
        .wr_idx_i  (k_q),
        .wr_data_i (ld_a),
        .rd_idx_i  (rd_idx),
        .rd_data_o (a_rd)
    );

    systolic_operand_bank #(
        .DATA_W (DATA_W),
        .N      (N),
        .K_MAX  (K_MAX),
        .IDX_W  (IDX_W)
    ) u_bank_b (
        .clk       (clk),
        .we_i      (wr_en),
        .wr_idx_i  (k_q),
        .wr_data_i (ld_b),
        .rd_idx_i  (rd_idx),
        .rd_data_o (b_rd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            klen_q  <= '0;
            k_q     <= '0;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            clr_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            k_q     <= k_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            clr_q   <= clr_d;
            ready_q <= (state_d == ST_LOAD);
            busy_q  <= (state_d == ST_LOAD) || stream_d;
            done_q  <= (state_d == ST_DONE);
            err_q   <= err_d;
        end
    end

    assign ld_ready   = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign a_out      = a_q;
    assign b_out      = b_q;
    assign clear_diag = clr_q;

endmodule
